// File: rtl/oam_dma_pkg.sv
// oam_dma_pkg
//   Shared types and default constants for the OAM DMA master.
//   - addr_t / data_t : 16-bit address and 8-bit data as carried on the DataBus
//   - state_e         : transfer FSM encoding
//   - *_DEF           : default register address, OAM base and transfer length
package oam_dma_pkg;

  typedef logic [15:0] addr_t;
  typedef logic [7:0]  data_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    RD    = 3'd2,
    LATCH = 3'd3,
    WR    = 3'd4
  } state_e;

  localparam addr_t DMA_REG_ADDR_DEF = 16'hFF46;
  localparam addr_t OAM_BASE_DEF     = 16'hFE00;
  localparam int    XFER_LEN_DEF     = 160;

endpackage

// File: rtl/oam_dma_master.sv
// oam_dma_master
//   Game Boy OAM DMA register (0xFF46). A CPU write starts a copy of XFER_LEN
//   bytes from {value, 8'h00} into OAM, one bus read and one bus write per
//   byte, over the master side of the shared DataBus.
//
//   Optional build macro: OAM_DMA_ECHO_REMAP_EN
//     When defined, a source high byte in E0..FF is mirrored down to C0..DF
//     (echo RAM). The register readback always returns the written value.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   cpu_addr/wr/rd/wdata CPU slave port
//   cpu_rdata            register readback (combinational), FF off-address
//   m_gnt                bus granted this cycle
//   m_req/addr/rd/wr     master request, address and strobes
//   m_wdata              master write data
//   m_rdata              read data, valid the cycle after m_rd
//   busy, oam_lock       transfer in progress / CPU OAM access blocked
import oam_dma_pkg::*;

module oam_dma_master #(
  parameter addr_t DMA_REG_ADDR = DMA_REG_ADDR_DEF,
  parameter addr_t OAM_BASE     = OAM_BASE_DEF,
  parameter int    XFER_LEN     = XFER_LEN_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  input  logic        m_gnt,
  output logic        m_req,
  output logic [15:0] m_addr,
  output logic        m_rd,
  output logic        m_wr,
  output logic [7:0]  m_wdata,
  input  logic [7:0]  m_rdata,
  output logic        busy,
  output logic        oam_lock
);

  localparam data_t LAST_IDX = data_t'(XFER_LEN - 1);

  state_e state_q, state_d;
  data_t  reg_q, src_hi_q, idx_q, byte_q;
  data_t  src_hi_in;
  logic   reg_wr;
  logic   is_last;

  assign reg_wr  = cpu_wr && (cpu_addr == DMA_REG_ADDR);
  assign is_last = (idx_q == LAST_IDX);

`ifdef OAM_DMA_ECHO_REMAP_EN
  assign src_hi_in = (cpu_wdata >= 8'hE0) ? (cpu_wdata - 8'h20) : cpu_wdata;
`else
  assign src_hi_in = cpu_wdata;
`endif

  assign cpu_rdata = (cpu_rd && (cpu_addr == DMA_REG_ADDR)) ? reg_q : 8'hFF;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Register, source, index and latched byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_q    <= 8'h00;
      src_hi_q <= 8'h00;
      idx_q    <= 8'h00;
      byte_q   <= 8'h00;
    end else begin
      if (reg_wr) begin
        // A write at any time (including mid-transfer) restarts from byte 0.
        reg_q    <= cpu_wdata;
        src_hi_q <= src_hi_in;
        idx_q    <= 8'h00;
      end else if ((state_q == WR) && m_gnt && !is_last) begin
        idx_q <= idx_q + 8'h01;
      end
      // The read was already granted in RD, so capture regardless of m_gnt.
      if (state_q == LATCH) begin
        byte_q <= m_rdata;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (reg_wr) begin
      state_d = REQ;
    end else begin
      unique case (state_q)
        IDLE:    state_d = IDLE;
        REQ:     if (m_gnt) state_d = RD;
        RD:      if (m_gnt) state_d = LATCH;
        LATCH:   state_d = WR;
        WR:      if (m_gnt) state_d = is_last ? IDLE : RD;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    m_req   = 1'b0;
    m_addr  = 16'h0000;
    m_rd    = 1'b0;
    m_wr    = 1'b0;
    m_wdata = 8'h00;
    unique case (state_q)
      REQ:   m_req = 1'b1;
      RD: begin
        m_req  = 1'b1;
        m_addr = {src_hi_q, idx_q};
        m_rd   = m_gnt;
      end
      LATCH: m_req = 1'b1;
      WR: begin
        m_req   = 1'b1;
        m_addr  = OAM_BASE + {8'h00, idx_q};
        m_wdata = byte_q;
        // A simultaneous register write aborts this byte, including the last.
        m_wr    = m_gnt && !reg_wr;
      end
      default: ;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign oam_lock = busy;

endmodule

// File: tb/tb_oam_dma_master.sv
// tb_oam_dma_master
//   Self-checking bench for oam_dma_master. A byte-wide memory model answers
//   the master port; expected reads and writes are queued when a transfer is
//   started and checked as the DUT issues them.
//   Honours OAM_DMA_ECHO_REMAP_EN for the echo-RAM source case.
module tb_oam_dma_master;
  import oam_dma_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cpu_addr;
  logic        cpu_wr, cpu_rd;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        m_gnt, m_req, m_rd, m_wr;
  logic [15:0] m_addr;
  logic [7:0]  m_wdata, m_rdata;
  logic        busy, oam_lock;

  always #5 clk = ~clk;

  oam_dma_master dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr(cpu_addr), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .m_gnt(m_gnt), .m_req(m_req), .m_addr(m_addr), .m_rd(m_rd), .m_wr(m_wr),
    .m_wdata(m_wdata), .m_rdata(m_rdata),
    .busy(busy), .oam_lock(oam_lock)
  );

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } acc_t;

  logic [7:0]  mem [0:65535];
  acc_t        exp_wr_q[$];
  logic [15:0] exp_rd_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int gnt_mode = 1;            // 0: never, 1: always, 2: random
  int rd_cnt = 0, wr_cnt = 0, viol_cnt = 0, cyc = 0;
  int first_rd_cyc = -1, done_cyc = -1;
  logic busy_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_src(input logic [7:0] v);
`ifdef OAM_DMA_ECHO_REMAP_EN
    if (v >= 8'hE0) return v - 8'h20;
`endif
    return v;
  endfunction

  // Bus responder and monitor: drive at negedge, sample 3 time units later.
  initial begin
    logic        rd_pend;
    logic [7:0]  rd_data;
    logic [15:0] ea;
    acc_t        ew;
    rd_pend = 1'b0;
    rd_data = 8'h00;
    m_gnt   = 1'b0;
    m_rdata = 8'h00;
    forever begin
      @(negedge clk);
      case (gnt_mode)
        0:       m_gnt = 1'b0;
        1:       m_gnt = 1'b1;
        default: m_gnt = 1'($urandom_range(0, 1));
      endcase
      m_rdata = rd_pend ? rd_data : 8'($urandom);
      rd_pend = 1'b0;
      #3;
      cyc++;
      if (!m_gnt && (m_rd || m_wr)) viol_cnt++;
      if (m_rd) begin
        rd_cnt++;
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        rd_pend = 1'b1;
        rd_data = mem[m_addr];
        if (exp_rd_q.size() == 0) chk("rd_unexpected", 32'(m_addr), 32'hFFFF_FFFF);
        else begin
          ea = exp_rd_q.pop_front();
          chk("rd_addr", 32'(m_addr), 32'(ea));
        end
      end
      if (m_wr) begin
        wr_cnt++;
        if (exp_wr_q.size() == 0) chk("wr_unexpected", 32'(m_addr), 32'hFFFF_FFFF);
        else begin
          ew = exp_wr_q.pop_front();
          chk("wr_addr", 32'(m_addr), 32'(ew.a));
          chk("wr_data", 32'(m_wdata), 32'(ew.d));
        end
        mem[m_addr] = m_wdata;
      end
      if (busy_prev && !busy) done_cyc = cyc;
      busy_prev = busy;
    end
  end

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_wr    = 1'b1;
    @(negedge clk);
    cpu_wr    = 1'b0;
    cpu_addr  = 16'h0000;
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
    @(negedge clk);
    cpu_addr = a;
    cpu_rd   = 1'b1;
    #2;
    d = cpu_rdata;
    cpu_rd   = 1'b0;
    cpu_addr = 16'h0000;
  endtask

  task automatic push_xfer(input logic [7:0] v);
    logic [7:0] s;
    acc_t       w;
    s = model_src(v);
    for (int i = 0; i < 160; i++) begin
      exp_rd_q.push_back({s, 8'(i)});
      w.a = 16'hFE00 + 16'(i);
      w.d = mem[{s, 8'(i)}];
      exp_wr_q.push_back(w);
    end
  endtask

  task automatic start_marks();
    first_rd_cyc = -1;
    done_cyc     = -1;
    viol_cnt     = 0;
    for (int i = 0; i < 160; i++) mem[16'hFE00 + 16'(i)] = 8'h00;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      #4;
      n++;
    end
    chk("done_in_budget", 32'(busy), 32'd0);
  endtask

  task automatic wait_writes(input int base, input int target);
    int n = 0;
    while ((wr_cnt - base) < target && n < 2000) begin
      @(negedge clk);
      #4;
      n++;
    end
    chk("reach_byte", 32'(wr_cnt - base), 32'(target));
  endtask

  task automatic check_oam(input string tag, input logic [7:0] key);
    for (int i = 0; i < 160; i++)
      chk(tag, 32'(mem[16'hFE00 + 16'(i)]), 32'(8'(i) ^ key));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rv;
    int base_rd, base_wr;
    rst_n = 1'b0;
    cpu_addr = 16'h0000; cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_wdata = 8'h00;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 160; i++) begin
      mem[16'hC000 + 16'(i)] = 8'(i) ^ 8'h5A;
      mem[16'h8000 + 16'(i)] = 8'(i) ^ 8'h33;
      mem[16'h9000 + 16'(i)] = 8'(i) ^ 8'hA7;
      mem[16'hE100 + 16'(i)] = 8'(i) ^ 8'h11;
      mem[16'hC100 + 16'(i)] = 8'(i) ^ 8'hEE;
    end

    // Reset state
    repeat (3) @(negedge clk);
    cpu_addr = 16'hFF46; cpu_rd = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_lock", 32'(oam_lock), 0);
    chk("rst_req", 32'(m_req), 0);
    chk("rst_rd", 32'(m_rd), 0);
    chk("rst_wr", 32'(m_wr), 0);
    chk("rst_addr", 32'(m_addr), 0);
    chk("rst_wdata", 32'(m_wdata), 0);
    chk("rst_rdata", 32'(cpu_rdata), 32'h00);
    cpu_rd = 1'b0; cpu_addr = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;

    // Full-grant copy from 0xC000
    gnt_mode = 1;
    start_marks();
    cpu_write(16'hFF46, 8'hC0);
    push_xfer(8'hC0);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_lock", 32'(oam_lock), 1);
    wait_done(2000);
    chk("t1_latency", 32'(done_cyc - first_rd_cyc), 32'd480);
    chk("t1_wr_left", 32'(exp_wr_q.size()), 0);
    check_oam("t1_oam", 8'h5A);
    cpu_read(16'hFF46, rv);
    chk("t1_readback", 32'(rv), 32'hC0);

    // Random grant copy
    gnt_mode = 2;
    start_marks();
    cpu_write(16'hFF46, 8'hC0);
    push_xfer(8'hC0);
    wait_done(6000);
    gnt_mode = 1;
    chk("t2_no_strobe_wo_gnt", 32'(viol_cnt), 0);
    chk("t2_slower", 32'((done_cyc - first_rd_cyc) > 480), 1);
    chk("t2_wr_left", 32'(exp_wr_q.size()), 0);
    check_oam("t2_oam", 8'h5A);

    // Restart at byte 50
    start_marks();
    base_wr = wr_cnt;
    cpu_write(16'hFF46, 8'h80);
    push_xfer(8'h80);
    wait_writes(base_wr, 50);
    cpu_write(16'hFF46, 8'h90);
    chk("t3_pending", 32'(exp_wr_q.size()), 32'd110);
    exp_rd_q.delete();
    exp_wr_q.delete();
    push_xfer(8'h90);
    wait_done(2000);
    chk("t3_wr_left", 32'(exp_wr_q.size()), 0);
    check_oam("t3_oam", 8'hA7);

    // Echo-RAM source
    start_marks();
    cpu_write(16'hFF46, 8'hE1);
    push_xfer(8'hE1);
    wait_done(2000);
    chk("t4_wr_left", 32'(exp_wr_q.size()), 0);
`ifdef OAM_DMA_ECHO_REMAP_EN
    check_oam("t4_oam", 8'hEE);
`else
    check_oam("t4_oam", 8'h11);
`endif
    cpu_read(16'hFF46, rv);
    chk("t4_readback", 32'(rv), 32'hE1);

    // Reset at byte 20
    start_marks();
    base_wr = wr_cnt;
    cpu_write(16'hFF46, 8'hC0);
    push_xfer(8'hC0);
    wait_writes(base_wr, 20);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_req", 32'(m_req), 0);
    chk("t5_rd", 32'(m_rd), 0);
    chk("t5_wr", 32'(m_wr), 0);
    chk("t5_lock", 32'(oam_lock), 0);
    cpu_addr = 16'hFF46; cpu_rd = 1'b1;
    #1;
    chk("t5_rdata", 32'(cpu_rdata), 32'h00);
    cpu_rd = 1'b0; cpu_addr = 16'h0000;
    exp_rd_q.delete();
    exp_wr_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    base_rd = rd_cnt;
    base_wr = wr_cnt;
    repeat (30) @(negedge clk);
    #4;
    chk("t5_no_rd", 32'(rd_cnt - base_rd), 0);
    chk("t5_no_wr", 32'(wr_cnt - base_wr), 0);
    chk("t5_idle", 32'(busy), 0);

    // Other address
    cpu_read(16'hFF47, rv);
    chk("t6_rd_other", 32'(rv), 32'hFF);
    base_rd = rd_cnt;
    cpu_write(16'hFF47, 8'hC0);
    #1;
    chk("t6_no_busy_now", 32'(busy), 0);
    repeat (10) @(negedge clk);
    #4;
    chk("t6_no_busy", 32'(busy), 0);
    chk("t6_no_rd", 32'(rd_cnt - base_rd), 0);
    cpu_read(16'hFF46, rv);
    chk("t6_reg_kept", 32'(rv), 32'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
